// File: rtl/quad_encoder_counter.sv
// Rotary encoder front end: pin synchronisers, per-input debounce, x1/x2/x4
// quadrature decode, wrap/saturate up/down counter, hex 7-segment digit and LED.
module quad_encoder_counter #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned MODE            = 4,
   parameter int unsigned SATURATE        = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             enc_btn,
   input  logic             enc_sw,
   output logic [WIDTH-1:0] count,
   output logic             step_pulse,
   output logic             dir,
   output logic             err_pulse,
   output logic             btn_pulse,
   output logic [6:0]       seg,
   output logic             led
);

   localparam int unsigned NCH   = 4;
   localparam int unsigned CH_A  = 0;
   localparam int unsigned CH_B  = 1;
   localparam int unsigned CH_BT = 2;
   localparam int unsigned CH_SW = 3;
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [NCH-1:0] pins;
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;
   logic [NCH-1:0] filt;

   assign pins = {enc_sw, enc_btn, enc_b, enc_a};

   // Two-flop synchronisers for all asynchronous pins
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filt = sync2;
      end else begin : g_filter
         for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [CNT_W-1:0] stable_cnt;
            logic             filt_q;

            // Filtered value follows the synced value only after an unbroken run of mismatches
            always_ff @(posedge clk) begin
               if (rst) begin
                  stable_cnt <= '0;
                  filt_q     <= 1'b0;
               end else if (sync2[i] == filt_q) begin
                  stable_cnt <= '0;
               end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable_cnt <= '0;
                  filt_q     <= sync2[i];
               end else begin
                  stable_cnt <= stable_cnt + CNT_W'(1);
               end
            end

            assign filt[i] = filt_q;
         end
      end
   endgenerate

   logic [1:0] cur_ab;
   logic [1:0] prev_ab;
   logic       btn_prev;
   logic       up_edge;
   logic       dn_edge;
   logic       bad_edge;
   logic       gate;
   logic       evt_step;
   logic       evt_up;
   logic       evt_err;
   logic       evt_btn;

   assign cur_ab = {filt[CH_A], filt[CH_B]};

   // Transition classification of {previous AB, current AB}; A leading B is up
   always_comb begin
      up_edge  = 1'b0;
      dn_edge  = 1'b0;
      bad_edge = 1'b0;
      gate     = 1'b1;
      case ({prev_ab, cur_ab})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: up_edge  = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: dn_edge  = 1'b1;
         4'b0011, 4'b1100, 4'b1001, 4'b0110: bad_edge = 1'b1;
         default: ;
      endcase
      if (MODE == 1) begin
         gate = (cur_ab == 2'b11);
      end else if (MODE == 2) begin
         gate = (cur_ab[1] == cur_ab[0]);
      end
   end

   // Event stage: one registered event per filtered transition
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_ab  <= 2'b00;
         btn_prev <= 1'b0;
         evt_step <= 1'b0;
         evt_up   <= 1'b0;
         evt_err  <= 1'b0;
         evt_btn  <= 1'b0;
      end else begin
         prev_ab  <= cur_ab;
         btn_prev <= filt[CH_BT];
         evt_step <= (up_edge | dn_edge) & gate;
         evt_up   <= up_edge;
         evt_err  <= bad_edge;
         evt_btn  <= filt[CH_BT] & ~btn_prev;
      end
   end

   logic [WIDTH-1:0] count_next;

   // Button clear has priority over any step landing in the same cycle
   always_comb begin
      count_next = count;
      if (evt_btn) begin
         count_next = '0;
      end else if (evt_step) begin
         if (evt_up) begin
            if (!((SATURATE != 0) && (count == CNT_MAX))) begin
               count_next = count + WIDTH'(1);
            end
         end else begin
            if (!((SATURATE != 0) && (count == '0))) begin
               count_next = count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         step_pulse <= 1'b0;
         dir        <= 1'b0;
         err_pulse  <= 1'b0;
         btn_pulse  <= 1'b0;
      end else begin
         count      <= count_next;
         step_pulse <= evt_step;
         err_pulse  <= evt_err;
         btn_pulse  <= evt_btn;
         if (evt_step) begin
            dir <= evt_up;
         end
      end
   end

   assign led = filt[CH_SW];

   logic [3:0] nib;

   assign nib = 4'(count);

   // Active-low hex glyphs, seg[0]=a .. seg[6]=g
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule
